// File: rtl/tl45_hazard_ctrl_if.sv
// Decode/execute/writeback signal bundle for the tl45 hazard controller.
// master = pipeline side driving decode/ex/wb status, slave = the controller.
interface tl45_hazard_ctrl_if;
    logic        i_dec_valid;
    logic [4:0]  i_dec_opcode;
    logic [3:0]  i_dec_dr;
    logic [3:0]  i_dec_sr1;
    logic [3:0]  i_dec_sr2;
    logic        i_dec_err;
    logic        i_ex_ready;
    logic        i_wb_valid;
    logic [3:0]  i_wb_dr;
    logic        i_br_taken;
    logic        o_issue;
    logic        o_pipe_stall;
    logic        o_pipe_flush;
    logic        o_halted;
    logic        o_sb_err;
    logic [15:0] o_busy_regs;

    modport master (
        output i_dec_valid, i_dec_opcode, i_dec_dr, i_dec_sr1, i_dec_sr2, i_dec_err,
        output i_ex_ready, i_wb_valid, i_wb_dr, i_br_taken,
        input  o_issue, o_pipe_stall, o_pipe_flush, o_halted, o_sb_err, o_busy_regs
    );

    modport slave (
        input  i_dec_valid, i_dec_opcode, i_dec_dr, i_dec_sr1, i_dec_sr2, i_dec_err,
        input  i_ex_ready, i_wb_valid, i_wb_dr, i_br_taken,
        output o_issue, o_pipe_stall, o_pipe_flush, o_halted, o_sb_err, o_busy_regs
    );
endinterface

// File: rtl/tl45_hazard_ctrl.sv
// Decode->execute scheduler: register scoreboard, issue gating, branch flush sequencing
// and halt on decode error. Outputs are combinational from registered state + inputs.
module tl45_hazard_ctrl #(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    tl45_hazard_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       MAX_Q      = 4'(MAX_INFLIGHT);
    localparam logic [4:0]       OP_IN      = 5'h10;
    localparam logic [4:0]       OP_OUT     = 5'h11;
    localparam logic [15:0]      REG_MASK   = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [15:0]      busy_q, busy_d;
    logic [3:0]       inflight_q, inflight_d;
    logic             sb_err_q, sb_err_d;

    logic [15:0] dr_oh, sr1_oh, sr2_oh, wb_oh;
    logic [15:0] busy_eff, set_mask, clr_mask;
    logic [3:0]  inflight_after;
    logic        dr_nz, wb_nz, wb_hit, wb_miss;
    logic        raw_haz, waw_haz, io_haz, cap_haz, hazard;
    logic        in_run, in_flush, in_halt;
    logic        issue, set_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_decode
            assign dr_oh[gi]  = (bus.i_dec_dr  == 4'(gi));
            assign sr1_oh[gi] = (bus.i_dec_sr1 == 4'(gi));
            assign sr2_oh[gi] = (bus.i_dec_sr2 == 4'(gi));
            assign wb_oh[gi]  = (bus.i_wb_dr   == 4'(gi));
        end
    endgenerate

    assign in_run   = (state_q == ST_RUN);
    assign in_flush = (state_q == ST_FLUSH);
    assign in_halt  = (state_q == ST_HALT);

    assign dr_nz = (bus.i_dec_dr != 4'd0);
    assign wb_nz = (bus.i_wb_dr != 4'd0);

    // A writeback only retires if its register is actually marked busy.
    assign wb_hit  = bus.i_wb_valid & wb_nz & |(wb_oh & busy_q);
    assign wb_miss = bus.i_wb_valid & wb_nz & ~wb_hit;

    assign busy_eff       = busy_q & ~(bus.i_wb_valid ? wb_oh : 16'h0000);
    assign inflight_after = inflight_q - {3'b000, wb_hit};

    assign raw_haz = |(busy_eff & (sr1_oh | sr2_oh));
    assign waw_haz = dr_nz & |(busy_eff & dr_oh);
    assign io_haz  = ((bus.i_dec_opcode == OP_IN) | (bus.i_dec_opcode == OP_OUT))
                     & (inflight_after != 4'd0);
    assign cap_haz = dr_nz & (inflight_after == MAX_Q);
    assign hazard  = raw_haz | waw_haz | io_haz | cap_haz;

    assign issue = ~i_reset & in_run & bus.i_dec_valid & ~hazard & bus.i_ex_ready
                   & ~bus.i_br_taken & ~bus.i_dec_err;

    assign bus.o_issue      = issue;
    assign bus.o_pipe_stall = ~i_reset & (in_halt | (in_run & bus.i_dec_valid & ~issue
                                                     & ~bus.i_br_taken));
    assign bus.o_pipe_flush = ~i_reset & in_flush;
    assign bus.o_halted     = ~i_reset & in_halt;
    assign bus.o_sb_err     = sb_err_q;
    assign bus.o_busy_regs  = i_reset ? 16'h0000 : busy_q;

    // Scoreboard: a same-register set and clear nets to "still busy, count unchanged".
    assign set_bit  = issue & dr_nz;
    assign set_mask = set_bit ? dr_oh : 16'h0000;
    assign clr_mask = wb_hit ? wb_oh : 16'h0000;

    always_comb begin
        busy_d     = ((busy_q & ~clr_mask) | set_mask) & REG_MASK;
        inflight_d = inflight_q + {3'b000, set_bit} - {3'b000, wb_hit};
        sb_err_d   = sb_err_q | wb_miss;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.i_br_taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (bus.i_dec_err) begin
                    state_d = ST_HALT;
                end
            end
            ST_FLUSH: begin
                if (bus.i_br_taken) begin
                    flush_cnt_d = FLUSH_LOAD;
                end else if (flush_cnt_q == CNT_ONE) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_ONE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            busy_q      <= '0;
            inflight_q  <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
            inflight_q  <= inflight_d;
            sb_err_q    <= sb_err_d;
        end
    end
endmodule

// File: tb/tb_tl45_hazard_ctrl.sv
// Bench for tl45_hazard_ctrl: directed scenarios then random traffic, every cycle
// compared against a queue-based model of in-flight writers.
module tb_tl45_hazard_ctrl;
    localparam int MAXI = 4;
    localparam int FC   = 2;
    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl45_hazard_ctrl_if bus ();

    tl45_hazard_ctrl #(
        .MAX_INFLIGHT(MAXI),
        .FLUSH_CYCLES(FC)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: the destination registers of issued, not yet written-back writers.
    int pending[$];
    int mode       = M_RUN;
    int flush_left = 0;
    bit m_sb_err   = 1'b0;
    bit m_issue    = 1'b0;

    function automatic bit in_flight(int r);
        foreach (pending[i]) if (pending[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] pend_mask();
        logic [15:0] m;
        m = '0;
        foreach (pending[i]) m[pending[i]] = 1'b1;
        return m;
    endfunction

    function automatic bit busy_now(int r, bit wbv, int wbd);
        return (r != 0) && in_flight(r) && !(wbv && wbd == r);
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, int op, int dr, int s1, int s2, bit err, bit exr,
                         bit wbv, int wbd, bit br);
        bus.i_dec_valid  = v;
        bus.i_dec_opcode = 5'(op);
        bus.i_dec_dr     = 4'(dr);
        bus.i_dec_sr1    = 4'(s1);
        bus.i_dec_sr2    = 4'(s2);
        bus.i_dec_err    = err;
        bus.i_ex_ready   = exr;
        bus.i_wb_valid   = wbv;
        bus.i_wb_dr      = 4'(wbd);
        bus.i_br_taken   = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Settle, derive expected outputs from the model, compare all of them.
    task automatic eval();
        int op, dr, s1, s2, wbd, infl_after;
        bit wbv, wb_ret, io, hz, exp_stall;
        #2;
        op  = int'(bus.i_dec_opcode);
        dr  = int'(bus.i_dec_dr);
        s1  = int'(bus.i_dec_sr1);
        s2  = int'(bus.i_dec_sr2);
        wbv = bus.i_wb_valid;
        wbd = int'(bus.i_wb_dr);
        wb_ret     = wbv && wbd != 0 && in_flight(wbd);
        infl_after = pending.size() - int'(wb_ret);
        io = (op == 16) || (op == 17);
        hz = busy_now(s1, wbv, wbd) || busy_now(s2, wbv, wbd) ||
             (dr != 0 && busy_now(dr, wbv, wbd)) ||
             (io && infl_after != 0) || (dr != 0 && infl_after == MAXI);
        m_issue = !rst && mode == M_RUN && bus.i_dec_valid && !hz && bus.i_ex_ready &&
                  !bus.i_br_taken && !bus.i_dec_err;
        exp_stall = !rst && (mode == M_HALT ||
                    (mode == M_RUN && bus.i_dec_valid && !m_issue && !bus.i_br_taken));
        chk("issue",  16'(bus.o_issue),      16'(m_issue));
        chk("stall",  16'(bus.o_pipe_stall), 16'(exp_stall));
        chk("flush",  16'(bus.o_pipe_flush), 16'(!rst && mode == M_FLUSH));
        chk("halted", 16'(bus.o_halted),     16'(!rst && mode == M_HALT));
        chk("sb_err", 16'(bus.o_sb_err),     16'(m_sb_err));
        chk("busy",   bus.o_busy_regs,       rst ? 16'h0000 : pend_mask());
        $display("cyc %0d rst=%0b v=%0b op=%02h dr=%0d s1=%0d s2=%0d err=%0b rdy=%0b wb=%0b/%0d br=%0b -> issue=%0b stall=%0b flush=%0b halt=%0b sb=%0b busy=%04h",
                 cyc, rst, bus.i_dec_valid, op, dr, s1, s2, bus.i_dec_err, bus.i_ex_ready,
                 wbv, wbd, bus.i_br_taken, bus.o_issue, bus.o_pipe_stall, bus.o_pipe_flush,
                 bus.o_halted, bus.o_sb_err, bus.o_busy_regs);
    endtask

    task automatic tick();
        int wbd, idx;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pending.delete();
            mode       = M_RUN;
            flush_left = 0;
            m_sb_err   = 1'b0;
        end else begin
            wbd = int'(bus.i_wb_dr);
            if (bus.i_wb_valid && wbd != 0) begin
                idx = -1;
                foreach (pending[i]) if (pending[i] == wbd) idx = i;
                if (idx >= 0) pending.delete(idx);
                else m_sb_err = 1'b1;
            end
            if (m_issue && bus.i_dec_dr != 4'd0) pending.push_back(int'(bus.i_dec_dr));
            case (mode)
                M_RUN: begin
                    if (bus.i_br_taken) begin
                        mode       = M_FLUSH;
                        flush_left = FC;
                    end else if (bus.i_dec_err) begin
                        mode = M_HALT;
                    end
                end
                M_FLUSH: begin
                    if (bus.i_br_taken) flush_left = FC;
                    else begin
                        flush_left--;
                        if (flush_left == 0) mode = M_RUN;
                    end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    initial begin
        bit v, err, exr, wbv, br;
        int op, dr, s1, s2, wbd, r;

        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        eval(); chk("rst_busy_zero", bus.o_busy_regs, 16'h0000); tick();
        rst = 1'b0;
        idle(); eval(); chk("idle_no_stall", 16'(bus.o_pipe_stall), 16'h0000); tick();

        // RAW on r3, released by same-cycle writeback
        drive(1, 1, 3, 1, 2, 0, 1, 0, 0, 0); eval(); chk("raw_first_issue", 16'(bus.o_issue), 16'h0001); tick();
        drive(1, 1, 4, 3, 1, 0, 1, 0, 0, 0); eval();
        chk("raw_busy_r3", bus.o_busy_regs, 16'h0008);
        chk("raw_stall", 16'(bus.o_pipe_stall), 16'h0001); tick();
        eval(); chk("raw_stall_held", 16'(bus.o_pipe_stall), 16'h0001); tick();
        drive(1, 1, 4, 3, 1, 0, 1, 1, 3, 0); eval(); chk("raw_bypass_issue", 16'(bus.o_issue), 16'h0001); tick();
        idle(); eval(); chk("raw_busy_r4", bus.o_busy_regs, 16'h0010); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 4, 0); eval(); tick();

        // Single branch: two flush cycles
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1); eval(); chk("br_cycle_no_flush", 16'(bus.o_pipe_flush), 16'h0000); tick();
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); eval();
        chk("flush_1", 16'(bus.o_pipe_flush), 16'h0001);
        chk("flush_no_issue", 16'(bus.o_issue), 16'h0000); tick();
        eval(); chk("flush_2", 16'(bus.o_pipe_flush), 16'h0001); tick();
        eval(); chk("flush_done", 16'(bus.o_pipe_flush), 16'h0000);
        chk("post_flush_issue", 16'(bus.o_issue), 16'h0001); tick();

        // Second branch in first flush cycle: three flush cycles
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1); eval(); tick();
        eval(); chk("ext_flush_1", 16'(bus.o_pipe_flush), 16'h0001); tick();
        idle(); eval(); chk("ext_flush_2", 16'(bus.o_pipe_flush), 16'h0001); tick();
        eval(); chk("ext_flush_3", 16'(bus.o_pipe_flush), 16'h0001); tick();
        eval(); chk("ext_flush_end", 16'(bus.o_pipe_flush), 16'h0000); tick();

        // In-flight cap
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, k, 0, 0, 0, 1, 0, 0, 0); eval(); chk("cap_fill", 16'(bus.o_issue), 16'h0001); tick();
        end
        drive(1, 1, 5, 0, 0, 0, 1, 0, 0, 0); eval(); chk("cap_stall", 16'(bus.o_pipe_stall), 16'h0001); tick();
        drive(1, 1, 5, 0, 0, 0, 1, 1, 1, 0); eval(); chk("cap_bypass_issue", 16'(bus.o_issue), 16'h0001); tick();
        idle(); eval(); chk("cap_busy", bus.o_busy_regs, 16'h003C); tick();
        for (int k = 2; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1, k, 0); eval(); tick();
        end

        // OUT serialised behind two writers
        drive(1, 1, 6, 0, 0, 0, 1, 0, 0, 0); eval(); tick();
        drive(1, 1, 7, 0, 0, 0, 1, 0, 0, 0); eval(); tick();
        drive(1, 17, 0, 1, 0, 0, 1, 0, 0, 0); eval(); chk("out_stall", 16'(bus.o_pipe_stall), 16'h0001); tick();
        drive(1, 17, 0, 1, 0, 0, 1, 1, 6, 0); eval(); chk("out_one_left", 16'(bus.o_issue), 16'h0000); tick();
        drive(1, 17, 0, 1, 0, 0, 1, 1, 7, 0); eval(); chk("out_issue", 16'(bus.o_issue), 16'h0001); tick();
        idle(); eval(); chk("out_busy_clear", bus.o_busy_regs, 16'h0000); tick();

        // Halt on decode error; writeback still retires; reset recovers
        drive(1, 1, 2, 0, 0, 0, 1, 0, 0, 0); eval(); tick();
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0, 0); eval(); tick();
        idle(); eval();
        chk("halted", 16'(bus.o_halted), 16'h0001);
        chk("halt_stall", 16'(bus.o_pipe_stall), 16'h0001); tick();
        drive(1, 1, 5, 0, 0, 0, 1, 1, 2, 0); eval(); chk("halt_no_issue", 16'(bus.o_issue), 16'h0000); tick();
        idle(); eval(); chk("halt_wb_clear", bus.o_busy_regs, 16'h0000); tick();
        rst = 1'b1; eval(); chk("rst_masks_halt", 16'(bus.o_halted), 16'h0000); tick();
        rst = 1'b0; eval(); chk("halt_cleared", 16'(bus.o_halted), 16'h0000); tick();

        // Writeback to a non-busy register
        drive(0, 0, 0, 0, 0, 0, 1, 1, 7, 0); eval(); tick();
        idle(); eval(); chk("sb_err_set", 16'(bus.o_sb_err), 16'h0001); tick();
        drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 0); eval(); tick();
        idle(); eval();
        chk("sb_err_sticky", 16'(bus.o_sb_err), 16'h0001);
        chk("sb_busy_r1", bus.o_busy_regs, 16'h0002); tick();
        rst = 1'b1; eval(); tick();
        rst = 1'b0; eval(); chk("sb_err_reset", 16'(bus.o_sb_err), 16'h0000); tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            rst = (mode == M_HALT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 8);
            r = int'($urandom_range(0, 7));
            op = (r == 0) ? 16 : (r == 1) ? 17 : int'($urandom_range(1, 31));
            dr = int'($urandom_range(0, 7));
            s1 = int'($urandom_range(0, 7));
            s2 = int'($urandom_range(0, 7));
            err = ($urandom_range(0, 99) < 2);
            exr = ($urandom_range(0, 3) != 0);
            wbv = ($urandom_range(0, 9) < 4);
            if (pending.size() > 0 && $urandom_range(0, 3) != 0)
                wbd = pending[$urandom_range(0, pending.size() - 1)];
            else
                wbd = int'($urandom_range(0, 15));
            br = ($urandom_range(0, 99) < 8);
            drive(v, op, dr, s1, s2, err, exr, wbv, wbd, br);
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
